// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception codes, flush target, D/E lane map,
// and the per-stage control record.
package pipe_pkg;

    localparam int unsigned EXC_W = 5;

    // Exception codes (MIPS Cause.ExcCode encoding); 0 means no exception.
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    // Exception handler entry, loaded into the PC on flush.
    localparam logic [31:0] FLUSH_PC = 32'h0000_4180;

    // Lane assignment for the decode/execute boundary.
    localparam int unsigned LANE_V1  = 0;
    localparam int unsigned LANE_V2  = 1;
    localparam int unsigned LANE_EXT = 2;
    localparam int unsigned LANE_PC8 = 3;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [EXC_W-1:0] exc;
        logic             bd;
        logic             bj;
    } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CntMax = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage boundary register with stall, bubble, flush, valid bit and
// consecutive-stall counter. Priority: reset > flush > stall > bubble > load.
// Define PIPE_STAGE_PERF_CNT_EN to build the bubble/flush event counters;
// otherwise those ports read constant 0.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned EXC_W      = pipe_pkg::EXC_W,
    parameter logic [31:0] FLUSH_PC   = pipe_pkg::FLUSH_PC,
    parameter int unsigned HOLD_CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_stall,
    input  logic                    i_bubble,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [31:0]             i_pc,
    input  logic [31:0]             i_instr,
    input  logic [NUM_LANES*32-1:0] i_data,
    input  logic [EXC_W-1:0]        i_exc,
    input  logic                    i_bd,
    input  logic                    i_bj,
    output logic                    o_valid,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_instr,
    output logic [NUM_LANES*32-1:0] o_data,
    output logic [EXC_W-1:0]        o_exc,
    output logic                    o_bd,
    output logic                    o_bj,
    output logic [HOLD_CNT_W-1:0]   o_hold_cnt,
    output logic [31:0]             o_bubble_cnt,
    output logic [31:0]             o_flush_cnt
);

    localparam int unsigned DataW = NUM_LANES * 32;

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [DataW-1:0] data_q, data_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic             bd_q, bd_d;
    logic             bj_q, bj_d;

    // Payload next-state; defaults hold, which is exactly the stall behaviour.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        bj_d    = bj_q;
        if (i_flush) begin
            valid_d = 1'b0;
            pc_d    = FLUSH_PC;
            instr_d = '0;
            data_d  = '0;
            exc_d   = '0;
            bd_d    = 1'b0;
            bj_d    = 1'b0;
        end else if (!i_stall) begin
            if (i_bubble) begin
                // Keep PC/BD so an interrupt on the bubble reports a correct EPC.
                valid_d = 1'b0;
                pc_d    = i_pc;
                instr_d = '0;
                data_d  = '0;
                exc_d   = '0;
                bd_d    = i_bd;
                bj_d    = 1'b0;
            end else begin
                valid_d = i_valid;
                pc_d    = i_pc;
                instr_d = i_instr;
                data_d  = i_data;
                exc_d   = i_exc;
                bd_d    = i_bd;
                bj_d    = i_bj;
            end
        end
    end

    // Payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            bj_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            bj_q    <= bj_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_instr = instr_q;
    assign o_data  = data_q;
    assign o_exc   = exc_q;
    assign o_bd    = bd_q;
    assign o_bj    = bj_q;

    // Counts only while stalled; any flush or non-stall cycle restarts it.
    logic hold_clr;
    assign hold_clr = i_flush | ~i_stall;

    sat_counter #(
        .WIDTH (HOLD_CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (i_stall),
        .cnt   (o_hold_cnt)
    );

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        bubble_taken;

    assign bubble_taken = i_bubble & ~i_stall & ~i_flush;

    // Free-running wrap counters of bubbles and flushes actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (bubble_taken) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (i_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;
`else
    assign o_bubble_cnt = '0;
    assign o_flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed decode/execute pipeline latch; one instance per stage boundary (D/E, E/M, M/W).
- Carries PC, instruction, NUM_LANES generic 32-bit operand lanes, exception code, branch-delay (BD) flag and branch-taken flag.
- Adds hold (stall), bubble insertion, exception flush, a valid bit and a consecutive-stall counter.

Parameters:
- NUM_LANES, 4, number of 32-bit payload lanes (D/E: V1, V2, EXT, PC8).
- EXC_W, 5, exception code width.
- FLUSH_PC, 32'h0000_4180, PC value loaded on flush (exception handler entry).
- HOLD_CNT_W, 4, width of the saturating consecutive-stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_stall  in  1  hold all outputs this cycle
- i_bubble  in  1  insert NOP, keep PC/BD
- i_flush  in  1  exception flush
- i_valid  in  1  upstream slot holds a real instruction
- i_pc  in  32  upstream PC
- i_instr  in  32  upstream instruction
- i_data  in  NUM_LANES*32  packed lanes, lane 0 in bits [31:0]
- i_exc  in  EXC_W  upstream exception code, 0 = none
- i_bd  in  1  upstream instruction is in a delay slot
- i_bj  in  1  upstream branch/jump taken
- o_valid  out  1  registered valid
- o_pc  out  32  registered PC
- o_instr  out  32  registered instruction
- o_data  out  NUM_LANES*32  registered lanes
- o_exc  out  EXC_W  registered exception code
- o_bd  out  1  registered BD
- o_bj  out  1  registered branch-taken flag
- o_hold_cnt  out  HOLD_CNT_W  consecutive stall cycles, saturating
- o_bubble_cnt  out  32  bubbles inserted (PERF_CNT_EN only)
- o_flush_cnt  out  32  flushes taken (PERF_CNT_EN only)

Behaviour:
- Single register stage, one-cycle latency. All updates on posedge clk.
- Reset is synchronous, active-high, on clock clk.
- Reset values: all outputs 0, including o_pc, o_hold_cnt and the perf counters.
- Per-cycle priority: reset > i_flush > i_stall > i_bubble > load.
- Flush:
  - o_pc <= FLUSH_PC.
  - o_valid, o_instr, o_data, o_exc, o_bd, o_bj <= 0.
  - o_hold_cnt <= 0.
- Stall (and no flush): every payload output holds its value. o_hold_cnt increments, saturating at 2^HOLD_CNT_W-1.
- Bubble (no flush, no stall):
  - o_instr, o_data, o_exc, o_bj <= 0; o_valid <= 0.
  - o_pc <= i_pc and o_bd <= i_bd, so CP0 gets a correct EPC/BD if an interrupt lands on the bubble.
  - o_hold_cnt <= 0.
- Load: every output <= its matching input; o_valid <= i_valid; o_hold_cnt <= 0.
- Simultaneous events:
  - stall+bubble acts as stall.
  - flush+stall acts as flush.
  - flush+bubble acts as flush.
- Reset mid-stall clears the counter immediately. The next cycle behaves as load unless a control input is asserted.
- i_exc passes through unmodified; the block never generates exceptions.
- Inputs are not sampled while stalled; the upstream stage must hold its own values.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - o_bubble_cnt increments on every cycle where a bubble is taken, i.e. i_bubble with no reset, flush or stall.
  - o_flush_cnt increments on every cycle i_flush is taken, i.e. i_flush with no reset.
  - Both are 32-bit, wrap from 32'hFFFF_FFFF to 0, and clear on reset only.
- Undefined: both ports are tied to constant 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg:
  - EXC_W and the exception code constants (EXC_NONE = 0, etc.).
  - FLUSH_PC default.
  - Lane index constants for the D/E stage (LANE_V1 = 0, LANE_V2 = 1, LANE_EXT = 2, LANE_PC8 = 3).
  - Struct typedef for {pc, instr, exc, bd, bj}.
- One natural sub-module: sat_counter (parametrised width, inc/clr, saturating), used for o_hold_cnt.
- The perf counters are plain wrap counters kept inline.

Test Plan:
- Reset then load: after reset, o_pc = 0 and o_hold_cnt = 0. Then load i_pc = 32'h3000, i_instr = 32'h2408_0005, lane0 = 5, i_valid = 1 → next cycle outputs match and o_valid = 1.
- Stall hold and saturation: assert i_stall for 20 cycles with changing inputs → outputs frozen; o_hold_cnt counts 1..15 and stays at 15. Deassert → o_hold_cnt = 0 and the new inputs are loaded.
- Bubble keeps PC/BD: i_bubble = 1, i_pc = 32'h3010, i_bd = 1, i_exc = 5'd10 → o_instr = 0, o_exc = 0, o_valid = 0, o_pc = 32'h3010, o_bd = 1.
- Flush priority: i_flush = i_stall = i_bubble = 1 → o_pc = 32'h4180, all other outputs 0, o_hold_cnt = 0.
- Exception passthrough: i_exc = 5'd4, i_bj = 1 on a load → o_exc = 4 and o_bj = 1 one cycle later.
- With PIPE_STAGE_PERF_CNT_EN defined:
  - 3 bubbles, 2 flushes, and 1 bubble asserted together with stall → o_bubble_cnt = 3, o_flush_cnt = 2.
  - Without the macro both read 0.
